load_store_unit: RTL

- Memory-stage initiator for the pipeline's word-addressed data memory.
- Accepts one load/store request at a time from the execute/memory stage and converts byte addresses to word indices.
- Issues the memory's mem_rd/mem_wr/address/write-data strobes; sub-word stores use read-modify-write.
- Returns sign/zero-extended load data with a valid pulse; illegal accesses are flagged.

---
 rtl/load_store_unit_if.sv | 55 +++++
 rtl/load_store_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// ---------------------------------------------------------------------------
// load_store_unit_if
//
// Purpose: bundles the request/response handshake and the data-memory bus of
// the load/store unit into one interface.
//
// Modports:
//   master : the environment around the unit (pipeline requester and the
//            data memory). It drives req_* and mem_rdata and observes the rest.
//   slave  : the load/store unit itself.
//
// Signals:
//   req_valid/req_ready/req_we/req_size/req_unsigned/req_addr/req_wdata
//                       request handshake from the execute/memory stage
//   resp_valid/resp_rdata/resp_err
//                       one-cycle completion pulse with extended load data
//   mem_rd/mem_wr/mem_addr/mem_wdata/mem_rdata
//                       word-addressed data memory bus (read data one cycle
//                       after the mem_rd cycle)
// ---------------------------------------------------------------------------
interface load_store_unit_if #(
    parameter int ADDR_BITS = 32
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic [1:0]           req_size;
    logic                 req_unsigned;
    logic [ADDR_BITS-1:0] req_addr;
    logic [31:0]          req_wdata;

    logic                 resp_valid;
    logic [31:0]          resp_rdata;
    logic                 resp_err;

    logic                 mem_rd;
    logic                 mem_wr;
    logic [31:0]          mem_addr;
    logic [31:0]          mem_wdata;
    logic [31:0]          mem_rdata;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_rd, mem_wr, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_rd, mem_wr, mem_addr, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//
// Purpose: memory-stage initiator for a word-addressed data memory. Accepts
// one load/store at a time, turns the byte address into a word index, drives
// the memory strobes (sub-word stores use read-modify-write) and returns
// sign/zero-extended load data with a one-cycle valid pulse. Illegal accesses
// (reserved size, out-of-range word index, optionally misalignment) complete
// with resp_err and never touch memory.
//
// Ports:
//   clk   : clock, all state updates on the rising edge
//   reset : synchronous, active-low reset
//   bus   : load_store_unit_if.slave (request, response and memory bus)
//
// Configuration macro:
//   MISALIGN_TRAP_EN : when defined, misaligned halfword/word requests are
//                      errors. When undefined, the low address bits below the
//                      access size are ignored and the access is performed at
//                      the aligned address.
//
// Latency from the accept edge: error 1, word store 2, load 3,
// sub-word store 4 cycles to resp_valid. All outputs are registered.
// ---------------------------------------------------------------------------
module load_store_unit #(
    parameter int DEPTH     = 128,
    parameter int ADDR_BITS = 32
) (
    input  logic              clk,
    input  logic              reset,
    load_store_unit_if.slave  bus
);
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_WR,
        S_RESP
    } state_t;

    state_t      state_q;

    // Latched request
    logic        we_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [1:0]  lane_q;
    logic [15:0] wdata_q;      // only sub-word stores need the data after accept

    // Registered outputs
    logic        req_ready_q;
    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic        resp_err_q;
    logic        mem_rd_q;
    logic        mem_wr_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;

    // ------------------------------------------------------------------
    // Request decode (evaluated only while IDLE)
    // ------------------------------------------------------------------
    logic [ADDR_BITS-1:0] word_idx;
    logic                 misaligned;
    logic                 req_err;

    assign word_idx = bus.req_addr >> 2;

`ifdef MISALIGN_TRAP_EN
    assign misaligned = ((bus.req_size == SZ_HALF) && bus.req_addr[0]) ||
                        ((bus.req_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00));
`else
    // Low address bits are simply ignored: halfword lanes use addr[1] only and
    // words never look at addr[1:0].
    assign misaligned = 1'b0;
`endif

    assign req_err = (bus.req_size == SZ_RSVD) ||
                     (word_idx >= ADDR_BITS'(DEPTH)) ||
                     misaligned;

    // ------------------------------------------------------------------
    // Lane extraction (loads) and lane merge (sub-word stores), both
    // working on mem_rdata during CAP.
    // ------------------------------------------------------------------
    logic [7:0]  rd_byte [4];
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_ext_d;
    logic [31:0] merged_d;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic       lane_hit;
        logic [7:0] new_byte;

        assign rd_byte[gi] = bus.mem_rdata[8*gi +: 8];

        // A byte store replaces exactly one lane; a halfword store replaces
        // the two lanes of the half selected by addr[1].
        assign lane_hit = (size_q == SZ_BYTE) ? (lane_q == 2'(gi))
                                              : (lane_q[1] == 1'(gi / 2));
        assign new_byte = (size_q == SZ_BYTE) ? wdata_q[7:0]
                                              : wdata_q[8*(gi % 2) +: 8];
        assign merged_d[8*gi +: 8] = lane_hit ? new_byte : rd_byte[gi];
    end

    assign lane_b = rd_byte[lane_q];
    assign lane_h = lane_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

    always_comb begin
        load_ext_d = bus.mem_rdata;
        case (size_q)
            SZ_BYTE: load_ext_d = {{24{!unsigned_q && lane_b[7]}}, lane_b};
            SZ_HALF: load_ext_d = {{16{!unsigned_q && lane_h[15]}}, lane_h};
            default: load_ext_d = bus.mem_rdata;
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            we_q         <= 1'b0;
            size_q       <= SZ_BYTE;
            unsigned_q   <= 1'b0;
            lane_q       <= 2'b00;
            wdata_q      <= 16'h0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_addr_q   <= 32'h0;
            mem_wdata_q  <= 32'h0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        we_q        <= bus.req_we;
                        size_q      <= bus.req_size;
                        unsigned_q  <= bus.req_unsigned;
                        lane_q      <= bus.req_addr[1:0];
                        wdata_q     <= bus.req_wdata[15:0];
                        req_ready_q <= 1'b0;
                        if (req_err) begin
                            // Rejected: straight to the response, memory untouched.
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= 32'h0;
                            state_q      <= S_RESP;
                        end else if (bus.req_we && (bus.req_size == SZ_WORD)) begin
                            mem_addr_q  <= 32'(word_idx);
                            mem_wdata_q <= bus.req_wdata;
                            mem_wr_q    <= 1'b1;
                            state_q     <= S_WR;
                        end else begin
                            mem_addr_q  <= 32'(word_idx);
                            mem_rd_q    <= 1'b1;
                            state_q     <= S_RD;
                        end
                    end
                end

                S_RD: begin
                    mem_rd_q <= 1'b0;
                    state_q  <= S_CAP;
                end

                S_CAP: begin
                    if (we_q) begin
                        mem_wdata_q <= merged_d;
                        mem_wr_q    <= 1'b1;
                        state_q     <= S_WR;
                    end else begin
                        resp_rdata_q <= load_ext_d;
                        resp_err_q   <= 1'b0;
                        resp_valid_q <= 1'b1;
                        state_q      <= S_RESP;
                    end
                end

                S_WR: begin
                    mem_wr_q     <= 1'b0;
                    resp_rdata_q <= 32'h0;
                    resp_err_q   <= 1'b0;
                    resp_valid_q <= 1'b1;
                    state_q      <= S_RESP;
                end

                S_RESP: begin
                    // resp_rdata/resp_err hold until the next response.
                    resp_valid_q <= 1'b0;
                    req_ready_q  <= 1'b1;
                    state_q      <= S_IDLE;
                end

                default: begin
                    mem_rd_q     <= 1'b0;
                    mem_wr_q     <= 1'b0;
                    resp_valid_q <= 1'b0;
                    req_ready_q  <= 1'b1;
                    state_q      <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.mem_rd     = mem_rd_q;
    assign bus.mem_wr     = mem_wr_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;

endmodule
